clock_divider_bank: RTL

//   Parametrised bank of NUM_CH independent programmable clock dividers. It generalises the

---
 rtl/clock_divider_bank_if.sv | 36 +++
 rtl/clock_divider_bank.sv | 126 ++++++++++++
 2 files changed

// File: rtl/clock_divider_bank_if.sv
// rtl/clock_divider_bank_if.sv - channel enables, config handshake and divider outputs bundle
// Purpose: groups the non-clock signals of clock_divider_bank.
// Ports (signals):
//   ch_en[NUM_CH]    per-channel run enable (level)
//   cfg_valid        config request valid
//   cfg_ready        config slot free
//   cfg_ch[CH_W]     target channel index
//   cfg_div[CNT_W]   new divisor
//   cfg_mode         0 = toggle, 1 = pulse
//   tick[NUM_CH]     one-cycle event pulse per channel
//   clk_out[NUM_CH]  square wave (toggle) or tick copy (pulse)
// Modports: master drives enables/config, slave is the divider bank.
interface clock_divider_bank_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 21,
    parameter int CH_W   = 4
);
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;

    modport master (
        output ch_en, cfg_valid, cfg_ch, cfg_div, cfg_mode,
        input  cfg_ready, tick, clk_out
    );

    modport slave (
        input  ch_en, cfg_valid, cfg_ch, cfg_div, cfg_mode,
        output cfg_ready, tick, clk_out
    );
endinterface

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of NUM_CH programmable clock dividers with shared config slot
// Purpose: each channel counts 0..div while enabled and fires a registered one-cycle tick
//   at the terminal count; clk_out is a 50% square wave (toggle) or a copy of tick (pulse).
//   A one-deep pending register takes {ch, div, mode} over a valid/ready handshake and
//   applies it at the target's next terminal count, or on the next cycle if it is disabled.
// Ports:
//   clock_i   system clock, posedge
//   resetn_i  asynchronous active-low reset
//   bus       clock_divider_bank_if.slave (ch_en, cfg_*, tick, clk_out)
module clock_divider_bank #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 21,
    parameter int DEF_DIV = 2**21-1,
    parameter int CH_W    = 4
) (
    input  logic                  clock_i,
    input  logic                  resetn_i,
    clock_divider_bank_if.slave   bus
);
    localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
    localparam logic [CH_W:0]    NUM_CH_W  = (CH_W+1)'(NUM_CH);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  div_d [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;

    logic              pending_q, pending_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    logic [CNT_W-1:0]  pend_div_q, pend_div_d;
    logic              pend_mode_q, pend_mode_d;

    logic              cfg_in_range;

    assign cfg_in_range  = ({1'b0, bus.cfg_ch} < NUM_CH_W);
    assign bus.cfg_ready = ~pending_q;
    assign bus.tick      = tick_q;
    assign bus.clk_out   = clk_out_q;

    always_comb begin
        pending_d   = pending_q;
        pend_ch_d   = pend_ch_q;
        pend_div_d  = pend_div_q;
        pend_mode_d = pend_mode_q;
        mode_d      = mode_q;
        tick_d      = '0;
        clk_out_d   = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            div_d[i] = div_q[i];

            if (!bus.ch_en[i]) begin
                // Disabled channel: held idle, and a pending config lands immediately.
                cnt_d[i] = '0;
                if (pending_q && (pend_ch_q == CH_W'(i))) begin
                    div_d[i]  = pend_div_q;
                    mode_d[i] = pend_mode_q;
                    pending_d = 1'b0;
                end
            end else begin
                if (cnt_q[i] == div_q[i]) begin
                    // Terminal count: this event was timed by the old divisor; the new
                    // settings (if any) govern the periods that follow.
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    if (pending_q && (pend_ch_q == CH_W'(i))) begin
                        div_d[i]  = pend_div_q;
                        mode_d[i] = pend_mode_q;
                        pending_d = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end

                // Pulse follows tick; leaving pulse mode restarts the square wave at 0.
                if (mode_d[i]) begin
                    clk_out_d[i] = tick_d[i];
                end else if (mode_q[i]) begin
                    clk_out_d[i] = 1'b0;
                end else begin
                    clk_out_d[i] = clk_out_q[i] ^ tick_d[i];
                end
            end
        end

        // Out-of-range channel requests are acknowledged but never occupy the slot.
        if (bus.cfg_valid && !pending_q && cfg_in_range) begin
            pending_d   = 1'b1;
            pend_ch_d   = bus.cfg_ch;
            pend_div_d  = bus.cfg_div;
            pend_mode_d = bus.cfg_mode;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DEF_DIV_W;
            end
            mode_q      <= '0;
            tick_q      <= '0;
            clk_out_q   <= '0;
            pending_q   <= 1'b0;
            pend_ch_q   <= '0;
            pend_div_q  <= '0;
            pend_mode_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
            mode_q      <= mode_d;
            tick_q      <= tick_d;
            clk_out_q   <= clk_out_d;
            pending_q   <= pending_d;
            pend_ch_q   <= pend_ch_d;
            pend_div_q  <= pend_div_d;
            pend_mode_q <= pend_mode_d;
        end
    end
endmodule
